// File: rtl/hazard_tracker.sv
// hazard_tracker: scoreboard of in-flight writers after ID; generates load-use stall and forwarding selects.
// Define HAZARD_STATS_EN to add a 32-bit stall_count output.
module hazard_tracker #(
  parameter int DEPTH = 3,
  parameter int AW = 5,
  parameter int TW = 2,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [TW-1:0] id_tuse_rs,
  input  logic [TW-1:0] id_tuse_rt,
  input  logic          id_wen,
  input  logic [AW-1:0] id_waddr,
  input  logic [TW-1:0] id_tnew,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_count
`endif
);
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][AW-1:0] waddr_q, waddr_d;
  logic [DEPTH-1:0][TW-1:0] tnew_q, tnew_d;
  logic          rs_hit, rt_hit, rs_use, rt_use, hazard;
  logic [SW-1:0] rs_k, rt_k;
  logic [TW-1:0] rs_tnew, rt_tnew;
  // Scan oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    rs_hit = 1'b0;
    rs_k = '0;
    rs_tnew = '0;
    rt_hit = 1'b0;
    rt_k = '0;
    rt_tnew = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && waddr_q[i] == id_rs && id_rs != '0) begin
        rs_hit = 1'b1;
        rs_k = SW'(i + 1);
        rs_tnew = tnew_q[i];
      end
      if (vld_q[i] && waddr_q[i] == id_rt && id_rt != '0) begin
        rt_hit = 1'b1;
        rt_k = SW'(i + 1);
        rt_tnew = tnew_q[i];
      end
    end
    rs_use = id_tuse_rs != '1;
    rt_use = id_tuse_rt != '1;
    hazard = id_valid && ((rs_use && rs_hit && rs_tnew > id_tuse_rs) ||
                          (rt_use && rt_hit && rt_tnew > id_tuse_rt));
    stall = hazard && !flush && !reset;
    fwd_rs_sel = (rs_use && rs_hit && rs_tnew == '0) ? rs_k : '0;
    fwd_rt_sel = (rt_use && rt_hit && rt_tnew == '0) ? rt_k : '0;
  end
  always_comb begin
    vld_d[0] = id_valid && id_wen && id_waddr != '0 && !stall && !flush;
    waddr_d[0] = vld_d[0] ? id_waddr : '0;
    tnew_d[0] = vld_d[0] ? id_tnew : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      waddr_d[i] = waddr_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      waddr_q <= '0;
      tnew_q <= '0;
    end else begin
      vld_q <= vld_d;
      waddr_q <= waddr_d;
      tnew_q <= tnew_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  always_comb stall_count_d = stall ? stall_count_q + 32'd1 : stall_count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
  assign stall_count = stall_count_q;
`endif
endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter DEPTH, default 3: number of tracked stages after ID (stage 1 = EX ... stage DEPTH = WB).
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter TW, default 2: Tuse/Tnew width; all-ones Tuse (TUSE_NONE) means operand unused.
REQ-004 Derived SW = $clog2(DEPTH+1): forwarding select width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_rs, id_rt  input  AW each  ID source registers.
REQ-009 id_tuse_rs, id_tuse_rt  input  TW each  cycles until operand needed (0 = in ID).
REQ-010 id_wen  input  1  ID instruction writes a register.
REQ-011 id_waddr  input  AW  ID destination register.
REQ-012 id_tnew  input  TW  cycles from stage 1 until result produced.
REQ-013 flush  input  1  discard the ID instruction this cycle.
REQ-014 stall  output  1  hold PC and IF/ID; insert bubble into stage 1.
REQ-015 fwd_rs_sel, fwd_rt_sel  output  SW each  0 = register file, k = forward from stage k.

Function
REQ-016 Tracker holds per stage k (1..DEPTH) registers vld[k], waddr[k], tnew[k].
REQ-017 Each edge, stage 1 loads {1, id_waddr, id_tnew} when id_valid & id_wen & id_waddr!=0 & !stall & !flush; otherwise loads bubble {0, 0, 0}.
REQ-018 Each edge, stage k+1 loads stage k with tnew decremented, saturating at 0; stages 2..DEPTH always advance (stall does not freeze them).
REQ-019 Match for operand r at stage k: vld[k] & waddr[k]==r & r!=0; the youngest (smallest k) match governs; older matches are ignored.
REQ-020 Operand hazard: id_valid & tuse!=TUSE_NONE & governing match exists & tnew[k] > tuse.
REQ-021 stall = (rs hazard | rt hazard) & !flush, combinational, same cycle as inputs.
REQ-022 fwd sel = k when governing match has tnew[k]==0, else 0; forced 0 when no match, r==0, or tuse==TUSE_NONE.
REQ-023 Register $0 never matches and is never tracked.
REQ-024 Stall resolves without external action: governing tnew decrements each cycle, so stall is held at most max(id_tnew)-tuse cycles.
REQ-025 flush and stall simultaneous conditions: flush wins; stall = 0, stage 1 loads bubble.

Reset
REQ-026 reset asserted: all vld, waddr, tnew cleared to 0 immediately; stall = 0, fwd_rs_sel = fwd_rt_sel = 0.
REQ-027 reset mid-stall: stall drops in the same cycle; the tracker restarts empty on the first edge after deassertion.

Configuration
REQ-028 Macro HAZARD_STATS_EN: when defined, add output stall_count (32 bits), cleared by reset, incremented each edge while stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-029 Without HAZARD_STATS_EN: no stall_count port, no counter logic; all other behaviour identical.

Verification
REQ-030 Load-use: lw $8 (tnew=2), then addu rs=$8 (tuse_rs=1) -> stall=1 exactly one cycle; next cycle stall=0, fwd_rs_sel=0.
REQ-031 ALU-to-branch: addu $9 (tnew=1), then beq rs=$9 (tuse_rs=0) -> stall one cycle, then fwd_rs_sel=2 with stall=0.
REQ-032 Youngest wins: $5 written at stages 1 (tnew=1) and 2 (tnew=0), reader tuse=0 -> stall=1 (stage 1 governs), not fwd_rs_sel=2.
REQ-033 Zero/unused: producer $0 tnew=2 or reader tuse_rt=3 -> stall=0, fwd_rt_sel=0.
REQ-034 Flush/reset: flush=1 during a load-use hazard -> stall=0, stage 1 bubble; reset during stall -> stall=0 same cycle, all stages invalid.
REQ-035 Stats (HAZARD_STATS_EN): three load-use pairs -> stall_count=3; reset -> 0.
